watch_mode_ctrl: RTL and testbench
==================================

WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_FIELDS, default 3, the number of editable digit fields (1..4).
REQ-002 The block SHALL have parameter TICK_GATE, default 1; 1 means count_en is gated by tick, 0 means count_en is a level enable.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  single-cycle timebase enable (e.g. 10 ms).
REQ-006 btn_start  input  1  debounced single-cycle start/stop pulse.
REQ-007 btn_mode  input  1  debounced single-cycle mode/lap pulse.
REQ-008 btn_adj  input  1  debounced single-cycle adjust pulse.
REQ-009 count_en  output  1  increment enable to the least-significant digit counter.
REQ-010 clr  output  1  one-cycle synchronous clear to all digit counters.
REQ-011 set_load  output  NUM_FIELDS  one-hot, one-cycle load strobe per field.
REQ-012 init_val  output  4  value presented with set_load.
REQ-013 field_sel  output  2  field currently being edited.
REQ-014 lap_hold  output  1  display freeze while counters keep running.
REQ-015 state  output  3  encoded FSM state for display/debug.

Function
REQ-016 The FSM SHALL have states IDLE=0, RUN=1, PAUSE=2, LAP=3, SET=4; all other encodings SHALL return to IDLE on the next edge.
REQ-017 Every output SHALL be registered; a button pulse at edge N SHALL take effect on outputs at edge N+1.
REQ-018 IDLE: btn_start -> RUN; btn_mode -> SET with field_sel=0, init_val=0.
REQ-019 RUN: btn_start -> PAUSE; btn_mode -> LAP.
REQ-020 LAP: btn_mode -> RUN (lap_hold drops); btn_start -> PAUSE (lap_hold drops).
REQ-021 PAUSE: btn_start -> RUN; btn_mode -> IDLE with clr=1 for exactly one cycle.
REQ-022 SET: btn_adj SHALL increment init_val, wrapping from FIELD_MAX[field_sel] to 0.
REQ-023 SET: btn_mode SHALL assert set_load[field_sel] for one cycle with current init_val, then advance field_sel and zero init_val; after field NUM_FIELDS-1, return to IDLE.
REQ-024 count_en SHALL be 1 only in RUN or LAP, and (TICK_GATE=1) only in the cycle after tick=1.
REQ-025 lap_hold SHALL be 1 exactly while in LAP.
REQ-026 Simultaneous pulses: btn_start SHALL win over btn_mode, btn_mode over btn_adj; losers are discarded, not queued.
REQ-027 btn_adj outside SET, and btn_start in SET, SHALL be ignored.
REQ-028 clr and set_load SHALL never be asserted in the same cycle.

Reset
REQ-029 reset SHALL force state=IDLE, count_en=0, clr=1 for the cycle following reset deassertion, set_load=0, init_val=0, field_sel=0, lap_hold=0.
REQ-030 reset SHALL take priority over all buttons and tick, including mid-SET; partially edited values SHALL be discarded without set_load.

Structure
REQ-031 State encodings, FIELD_MAX table (9,5,9,5) and field-index width SHALL reside in shared package watch_pkg.
REQ-032 The SET-mode value editor (init_val wrap, field_sel advance, set_load decode) SHALL be a sub-module named watch_field_editor; the rest is one FSM.

Verification
REQ-033 Reset, release -> state=0, clr=1 one cycle, then all outputs 0.
REQ-034 IDLE, btn_start, 3 ticks -> state=1, exactly 3 count_en pulses each one cycle after tick.
REQ-035 RUN, btn_mode -> state=3, lap_hold=1, count_en continues; btn_mode -> state=1, lap_hold=0.
REQ-036 RUN, btn_start -> PAUSE, ticks produce no count_en; btn_mode -> state=0, one clr pulse.
REQ-037 IDLE, btn_mode, 7 btn_adj on field 1 (max 5) -> init_val=1; btn_mode -> set_load=3'b010 with init_val=1.
REQ-038 btn_start and btn_mode in same cycle from IDLE -> state=1, no SET entry; reset during SET -> IDLE, no set_load.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
package watch_pkg;

    // Width of the field index presented on field_sel.
    localparam int unsigned FIELD_W = 2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StPause = 3'd2,
        StLap   = 3'd3,
        StSet   = 3'd4
    } watch_state_e;

    // Highest legal digit per field: seconds/minutes style 9,5,9,5.
    function automatic logic [3:0] field_max(input logic [FIELD_W-1:0] idx);
        logic [3:0] max_val;
        unique case (idx)
            2'd0: max_val = 4'd9;
            2'd1: max_val = 4'd5;
            2'd2: max_val = 4'd9;
            2'd3: max_val = 4'd5;
        endcase
        return max_val;
    endfunction

endpackage

// File: rtl/watch_field_editor.sv
// SET-mode digit editor: adjusts the working value, strobes the load and steps fields.
module watch_field_editor
    import watch_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enter_i,
    input  logic                  adj_i,
    input  logic                  next_i,
    output logic [FIELD_W-1:0]    field_sel_o,
    output logic [3:0]            init_val_o,
    output logic [NUM_FIELDS-1:0] set_load_o,
    output logic                  done_o
);

    logic [FIELD_W-1:0]    field_sel_q, field_sel_d;
    logic [3:0]            init_val_q, init_val_d;
    logic [NUM_FIELDS-1:0] set_load_q, set_load_d;
    logic                  loading;
    logic                  last_field;

    // The load strobe cycle shows the loaded field and value; the step happens after it.
    assign loading    = |set_load_q;
    assign last_field = (field_sel_q == FIELD_W'(NUM_FIELDS - 1));

    // Next-state for the field index, working value and load strobe.
    always_comb begin
        field_sel_d = field_sel_q;
        init_val_d  = init_val_q;
        set_load_d  = '0;
        if (enter_i) begin
            field_sel_d = '0;
            init_val_d  = '0;
        end else if (loading) begin
            init_val_d  = '0;
            field_sel_d = last_field ? '0 : field_sel_q + 1'b1;
        end else if (next_i) begin
            for (int i = 0; i < int'(NUM_FIELDS); i++) begin
                set_load_d[i] = (field_sel_q == FIELD_W'(i));
            end
        end else if (adj_i) begin
            init_val_d = (init_val_q >= field_max(field_sel_q)) ? 4'd0 : init_val_q + 4'd1;
        end
    end

    // Editor registers; reset discards any partial edit.
    always_ff @(posedge clk) begin
        if (reset) begin
            field_sel_q <= '0;
            init_val_q  <= '0;
            set_load_q  <= '0;
        end else begin
            field_sel_q <= field_sel_d;
            init_val_q  <= init_val_d;
            set_load_q  <= set_load_d;
        end
    end

    assign field_sel_o = field_sel_q;
    assign init_val_o  = init_val_q;
    assign set_load_o  = set_load_q;
    assign done_o      = loading && last_field;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Stopwatch mode controller: run/pause/lap/set FSM driving digit counter controls.
module watch_mode_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 3,
    parameter int unsigned TICK_GATE  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  btn_start,
    input  logic                  btn_mode,
    input  logic                  btn_adj,
    output logic                  count_en,
    output logic                  clr,
    output logic [NUM_FIELDS-1:0] set_load,
    output logic [3:0]            init_val,
    output logic [1:0]            field_sel,
    output logic                  lap_hold,
    output logic [2:0]            state
);

    watch_state_e state_q, state_d;
    logic         count_en_q, count_en_d;
    logic         clr_q, clr_d;
    logic         lap_hold_q, lap_hold_d;
    logic         ed_enter, ed_next, ed_adj, ed_done;

    watch_field_editor #(
        .NUM_FIELDS (NUM_FIELDS)
    ) u_editor (
        .clk         (clk),
        .reset       (reset),
        .enter_i     (ed_enter),
        .adj_i       (ed_adj),
        .next_i      (ed_next),
        .field_sel_o (field_sel),
        .init_val_o  (init_val),
        .set_load_o  (set_load),
        .done_o      (ed_done)
    );

    // Next state and registered-output inputs; start beats mode beats adjust.
    always_comb begin
        state_d  = state_q;
        ed_enter = 1'b0;
        ed_next  = 1'b0;
        ed_adj   = 1'b0;
        case (state_q)
            StIdle: begin
                if (btn_start) begin
                    state_d = StRun;
                end else if (btn_mode) begin
                    state_d  = StSet;
                    ed_enter = 1'b1;
                end
            end
            StRun: begin
                if (btn_start)     state_d = StPause;
                else if (btn_mode) state_d = StLap;
            end
            StLap: begin
                if (btn_start)     state_d = StPause;
                else if (btn_mode) state_d = StRun;
            end
            StPause: begin
                if (btn_start)     state_d = StRun;
                else if (btn_mode) state_d = StIdle;
            end
            StSet: begin
                // btn_start has no meaning while editing.
                if (ed_done)      state_d = StIdle;
                else if (btn_mode) ed_next = 1'b1;
                else if (btn_adj)  ed_adj  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        clr_d      = (state_q == StPause) && !btn_start && btn_mode;
        count_en_d = ((state_d == StRun) || (state_d == StLap)) && ((TICK_GATE == 0) || tick);
        lap_hold_d = (state_d == StLap);
    end

    // State and output registers; clr is held high through reset and one cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_en_q <= 1'b0;
            clr_q      <= 1'b1;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_en_q <= count_en_d;
            clr_q      <= clr_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    assign state    = state_q;
    assign count_en = count_en_q;
    assign clr      = clr_q;
    assign lap_hold = lap_hold_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Table-driven scoreboard bench for watch_mode_ctrl (NUM_FIELDS=3, TICK_GATE=1).
module tb_watch_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_adj = 1'b0;
    logic       count_en;
    logic       clr;
    logic [2:0] set_load;
    logic [3:0] init_val;
    logic [1:0] field_sel;
    logic       lap_hold;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        logic       rst, st, md, adj, tk;
        logic [2:0] e_state;
        logic       e_cnt, e_clr;
        logic [2:0] e_load;
        logic [3:0] e_val;
        logic [1:0] e_fsel;
        logic       e_lap;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    watch_mode_ctrl #(
        .NUM_FIELDS (3),
        .TICK_GATE  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_start (btn_start),
        .btn_mode  (btn_mode),
        .btn_adj   (btn_adj),
        .count_en  (count_en),
        .clr       (clr),
        .set_load  (set_load),
        .init_val  (init_val),
        .field_sel (field_sel),
        .lap_hold  (lap_hold),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic md, input logic adj,
                       input logic tk, input logic [2:0] es, input logic ec, input logic ecl,
                       input logic [2:0] el, input logic [3:0] ev, input logic [1:0] ef,
                       input logic elap);
        vec_t v;
        v.rst = rst; v.st = st; v.md = md; v.adj = adj; v.tk = tk;
        v.e_state = es; v.e_cnt = ec; v.e_clr = ecl; v.e_load = el;
        v.e_val = ev; v.e_fsel = ef; v.e_lap = elap;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset = v.rst; btn_start = v.st; btn_mode = v.md; btn_adj = v.adj; tick = v.tk;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", idx, 8'(state), 8'(e.e_state));
        chk("count_en", idx, 8'(count_en), 8'(e.e_cnt));
        chk("clr", idx, 8'(clr), 8'(e.e_clr));
        chk("set_load", idx, 8'(set_load), 8'(e.e_load));
        chk("init_val", idx, 8'(init_val), 8'(e.e_val));
        chk("field_sel", idx, 8'(field_sel), 8'(e.e_fsel));
        chk("lap_hold", idx, 8'(lap_hold), 8'(e.e_lap));
    endtask

    // clr and set_load must never coincide.
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (clr && (|set_load)) begin
                n_fail++;
                $display("FAIL clr_vs_load: clr=%0b set_load=%0b required no overlap",
                         clr, set_load);
            end
        end
    end

    initial begin
        int pulses;
        // rst st md adj tk | state cnt clr load val fsel lap
        add(1, 0, 0, 0, 0, 3'd0, 0, 1, 3'b000, 4'd0, 2'd0, 0);
        add(1, 0, 0, 0, 1, 3'd0, 0, 1, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 1, 1, 3'd0, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 1, 0, 0, 0, 3'd1, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 1, 3'd1, 1, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 0, 3'd1, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 1, 3'd1, 1, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 1, 3'd1, 1, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 1, 0, 0, 3'd3, 0, 0, 3'b000, 4'd0, 2'd0, 1);
        add(0, 0, 0, 0, 1, 3'd3, 1, 0, 3'b000, 4'd0, 2'd0, 1);
        add(0, 0, 1, 0, 0, 3'd1, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 1, 0, 0, 0, 3'd2, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 1, 3'd2, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 1, 0, 3'd2, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 1, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        // SET: field 0
        add(0, 0, 1, 0, 0, 3'd4, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 1, 0, 0, 0, 3'd4, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 4'd1, 2'd0, 0);
        add(0, 0, 1, 0, 0, 3'd4, 0, 0, 3'b001, 4'd1, 2'd0, 0);
        add(0, 0, 0, 0, 0, 3'd4, 0, 0, 3'b000, 4'd0, 2'd1, 0);
        // field 1 wraps after 5: 1,2,3,4,5,0,1
        for (int i = 1; i <= 7; i++) add(0, 0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 4'(i % 6), 2'd1, 0);
        add(0, 0, 1, 0, 0, 3'd4, 0, 0, 3'b010, 4'd1, 2'd1, 0);
        add(0, 0, 0, 0, 0, 3'd4, 0, 0, 3'b000, 4'd0, 2'd2, 0);
        // field 2 wraps after 9
        for (int i = 1; i <= 10; i++) add(0, 0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 4'(i % 10), 2'd2, 0);
        add(0, 0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 4'd1, 2'd2, 0);
        add(0, 0, 1, 1, 0, 3'd4, 0, 0, 3'b100, 4'd1, 2'd2, 0);
        add(0, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        // priority cases
        add(0, 1, 1, 0, 1, 3'd1, 1, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 1, 0, 0, 1, 3'd2, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 1, 0, 0, 0, 3'd1, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 1, 1, 0, 0, 3'd2, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 1, 0, 0, 0, 3'd1, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 1, 0, 0, 3'd3, 0, 0, 3'b000, 4'd0, 2'd0, 1);
        add(0, 1, 1, 0, 0, 3'd2, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 1, 3'b000, 4'd0, 2'd0, 0);
        // reset mid-SET discards the edit
        add(0, 0, 1, 0, 0, 3'd4, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 4'd1, 2'd0, 0);
        add(0, 0, 1, 0, 0, 3'd4, 0, 0, 3'b001, 4'd1, 2'd0, 0);
        add(0, 0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 4'd0, 2'd1, 0);
        add(0, 0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 4'd1, 2'd1, 0);
        add(1, 1, 1, 1, 1, 3'd0, 0, 1, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000, 4'd0, 2'd0, 0);
        add(0, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000, 4'd0, 2'd0, 0);

        mon_en = 1'b1;
        foreach (vecs[i]) apply(vecs[i], i);

        // Spaced ticks in RUN: count_en mirrors the previous-cycle tick, three pulses total.
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        chk("run_entry", 0, 8'(state), 8'd1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tick = (i % 4 == 1);
            @(posedge clk);
            #1;
            chk("tick_gate", i, 8'(count_en), 8'(i % 4 == 1));
            if (count_en) pulses++;
        end
        chk("pulse_count", 0, 8'(pulses), 8'd3);

        @(negedge clk);
        tick = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
